mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: the MEM-stage load/store unit that issues MemRead/MemWrite/Address/Write_data and consumes readData.
- Turns pipeline load/store requests into word-aligned memory transactions with sign/zero extension, sub-word read-modify-write, alignment and range checking.
- Holds the pipeline with `busy` until each transaction completes.

Parameters:
- ADDR_BITS, 13, byte-address bits the data memory decodes (2048 words); any set bit above ADDR_BITS-1 is out of range.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present; sampled only when req_ready=1
- req_ready  out  1  high iff state=IDLE
- req_write  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data; sub-word stores use its low bits
- busy  out  1  high iff state!=IDLE (pipeline stall)
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  load result, valid with resp_valid; 0 for stores and errors
- resp_err  out  1  with resp_valid: misaligned, out-of-range or reserved size
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- Address  out  32  word-aligned address {addr[31:2],2'b00}; 0 in IDLE
- Write_data  out  32  word to write; 0 when MemWrite=0
- readData  in  32  memory read word; valid the cycle after the address is presented, only while MemRead=1

Behaviour:
- Reset: state=IDLE; latched request cleared; MemRead=0, MemWrite=0, Address=0, Write_data=0, resp_valid=0, resp_data=0, resp_err=0, busy=0, req_ready=1.
- Acceptance: in IDLE with req_valid=1, latch addr/size/unsigned/write/wdata at the clock edge. Memory outputs are driven from the latched copy only.
- Error check at acceptance:
  - size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:ADDR_BITS]!=0 -> ERR.
  - Otherwise choose the path below.
- States: IDLE, LD_ADDR, LD_DATA, ST_WORD, RMW_ADDR, RMW_DATA, RMW_WRITE, DONE, ERR.
- Load: LD_ADDR (MemRead=1) -> LD_DATA (MemRead=1; capture extracted/extended readData) -> DONE. resp_valid occurs 3 cycles after the accept edge.
- Word store: ST_WORD (MemWrite=1, Write_data=wdata) -> DONE. resp_valid occurs 2 cycles after accept.
- Byte/half store:
  - RMW_ADDR (MemRead=1) -> RMW_DATA (MemRead=1; capture readData with the target lane(s) replaced) -> RMW_WRITE (MemWrite=1, Write_data=merged word) -> DONE.
  - resp_valid occurs 4 cycles after accept.
- ERR: resp_valid=1, resp_err=1 for one cycle (1 cycle after accept). MemRead and MemWrite never assert. -> IDLE.
- DONE: resp_valid=1 for one cycle -> IDLE. The next request can be accepted in the following cycle, with no back-to-back acceptance from DONE.
- Lane mapping (little-endian):
  - byte n = readData[8n+7:8n], n=addr[1:0]
  - half at addr[1]=0 -> [15:0]; addr[1]=1 -> [31:16]
  - store lanes are placed identically; byte data = wdata[7:0], half data = wdata[15:0]
- MemRead and MemWrite are never high together. Address is held constant across all cycles of one transaction.
- resp_data/resp_err are registered and hold only during the resp_valid cycle; otherwise 0.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. A pending RMW write is dropped (no MemWrite), and no resp_valid is produced for the aborted request.
- req_valid while busy=1 is ignored. Requests are not queued.

Test Plan:
- sw addr 0x10, data 0xDEADBEEF; then lw 0x10 -> MemWrite exactly 1 cycle with Write_data 0xDEADBEEF; load resp_data=0xDEADBEEF 3 cycles after accept, resp_err=0.
- lb 0x11 and lbu 0x11 on word 0xDEADBEEF -> resp_data 0xFFFFFFBE and 0x000000BE; lh 0x12 -> 0xFFFFDEAD; lhu 0x12 -> 0x0000DEAD.
- sb 0x12, wdata 0x123456AA on word 0xDEADBEEF -> MemRead 2 cycles, then MemWrite 1 cycle with Write_data 0xDEAABEEF, Address 0x10, resp_valid 4 cycles after accept. Subsequent lw 0x10 -> 0xDEAABEEF.
- Error cases: lh 0x11, sw 0x12, size=11, lw 0x00002000 (ADDR_BITS=13) -> each gives resp_valid=1, resp_err=1, resp_data=0 one cycle after accept; no MemRead/MemWrite.
- reset=1 during RMW_DATA of sb 0x10 -> no MemWrite ever issued, no resp_valid; req_ready=1 and busy=0 the cycle after reset deasserts; memory word unchanged.
- req_valid held high across a load -> exactly one accept; busy=1 for 3 cycles; second accept only in the cycle after resp_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for the data memory.
// Accepts one load/store request at a time, issues word-aligned memory
// transactions (read-modify-write for byte/half stores), extends loads and
// reports misaligned, out-of-range or reserved-size requests as errors.
module mem_access_unit #(
  parameter int ADDR_BITS = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] readData
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LD_ADDR   = 4'd1,
    S_LD_DATA   = 4'd2,
    S_ST_WORD   = 4'd3,
    S_RMW_ADDR  = 4'd4,
    S_RMW_DATA  = 4'd5,
    S_RMW_WRITE = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        req_bad_s;

  // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of a memory word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      SZ_BYTE: r[{off, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: begin
        if (off[1]) begin
          r[31:16] = wd;
        end else begin
          r[15:0] = wd;
        end
      end
      default: r = word;
    endcase
    return r;
  endfunction

  // Reject reserved sizes, misaligned halves/words and addresses beyond the memory.
  always_comb begin
    req_bad_s = 1'b0;
    case (req_size)
      SZ_BYTE: req_bad_s = 1'b0;
      SZ_HALF: req_bad_s = req_addr[0];
      SZ_WORD: req_bad_s = (req_addr[1:0] != 2'b00);
      default: req_bad_s = 1'b1;
    endcase
    if ((req_addr >> ADDR_BITS) != 32'd0) begin
      req_bad_s = 1'b1;
    end else begin
      req_bad_s = req_bad_s;
    end
  end

  // Next-state, request latch and response computation.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    resp_data_d  = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          if (req_bad_s) begin
            state_d = S_ERR;
          end else if (!req_write) begin
            state_d = S_LD_ADDR;
          end else if (req_size == SZ_WORD) begin
            state_d = S_ST_WORD;
          end else begin
            state_d = S_RMW_ADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LD_ADDR:   state_d = S_LD_DATA;
      S_LD_DATA: begin
        state_d     = S_DONE;
        resp_data_d = load_extract(readData, addr_q[1:0], size_q, uns_q);
      end
      S_ST_WORD:   state_d = S_DONE;
      S_RMW_ADDR:  state_d = S_RMW_DATA;
      S_RMW_DATA: begin
        state_d = S_RMW_WRITE;
        wdata_d = store_merge(readData, wdata_q[15:0], addr_q[1:0], size_q);
      end
      S_RMW_WRITE: state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      S_ERR:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    resp_valid_d = (state_d == S_DONE) || (state_d == S_ERR);
    resp_err_d   = (state_d == S_ERR);
  end

  // State, latched request and registered response; reset aborts any transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= 32'd0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Memory strobes decoded from the state register and the latched request only.
  always_comb begin
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Write_data = 32'd0;
    Address    = (state_q == S_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
    case (state_q)
      S_LD_ADDR, S_LD_DATA, S_RMW_ADDR, S_RMW_DATA: MemRead = 1'b1;
      S_ST_WORD, S_RMW_WRITE: begin
        MemWrite   = 1'b1;
        Write_data = wdata_q;
      end
      default: MemRead = 1'b0;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset-abort and
// held-request sequences, then random traffic against a transaction-level model.
module tb_mem_access_unit;

  localparam int AB = 13;
  localparam int NW = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, busy, resp_valid, resp_err, MemRead, MemWrite;
  logic [31:0] resp_data, Address, Write_data, readData;

  mem_access_unit #(.ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .Write_data(Write_data), .readData(readData)
  );

  always #5 clk = ~clk;

  // Data memory: one-cycle read latency, garbage on readData when not reading.
  logic [31:0] mem [NW];
  logic [31:0] rd_q;
  logic        mem_init;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
    end else if (MemWrite) begin
      mem[Address[12:2]] <= Write_data;
    end
    rd_q <= MemRead ? mem[Address[12:2]] : $urandom;
  end
  assign readData = rd_q;

  // Reference model state: the memory as the transaction rules say it should be.
  logic [31:0] ref_mem [NW];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
    end
  endtask

  // Transaction-level model: expected response, latency and memory traffic.
  task automatic model(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] ed, output logic ee, output int lat,
                       output int nrd, output int nwr, output logic [31:0] ewd);
    logic [31:0] word, v, mask;
    int idx, sh;
    ed = 32'd0; ee = 1'b0; lat = 0; nrd = 0; nwr = 0; ewd = 32'd0;
    ee = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
         || (a >= 32'(1 << AB));
    if (ee) begin
      lat = 1;
    end else begin
      idx  = int'(a / 4);
      sh   = int'(a % 4) * 8;
      word = ref_mem[idx];
      if (!w) begin
        lat = 3; nrd = 2;
        if (sz == 2'd0) begin
          v = (word >> sh) & 32'hFF;
          if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          v = (word >> sh) & 32'hFFFF;
          if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
          v = word;
        end
        ed = v;
      end else if (sz == 2'd2) begin
        lat = 2; nwr = 1; ewd = wd;
        ref_mem[idx] = wd;
      end else begin
        lat = 4; nrd = 2; nwr = 1;
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        ewd = (word & ~mask) | ((wd << sh) & mask);
        ref_mem[idx] = ewd;
      end
    end
  endtask

  // Drive one request, wait for its response, and record what the DUT did.
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output logic err,
                         output int nrd, output int nwr, output logic [31:0] wr_word,
                         output logic addr_bad, output logic mutex_bad,
                         output logic pulse_bad);
    int waitc;
    lat = 0; data = 32'd0; err = 1'b0; nrd = 0; nwr = 0; wr_word = 32'd0;
    addr_bad = 1'b0; mutex_bad = 1'b0; pulse_bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    for (int c = 1; c <= 12; c++) begin
      if (MemRead) nrd++;
      if (MemWrite) begin
        nwr++;
        wr_word = Write_data;
      end
      if (MemRead && MemWrite) mutex_bad = 1'b1;
      if ((MemRead || MemWrite) && Address !== {a[31:2], 2'b00}) addr_bad = 1'b1;
      if (resp_valid) begin
        lat  = c;
        data = resp_data;
        err  = resp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (resp_valid || resp_data != 32'd0 || resp_err) pulse_bad = 1'b1;
  endtask

  task automatic exec(input logic w, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input int elat,
                      input int enrd, input int enwr, input logic [31:0] ewd);
    int lat, nrd, nwr;
    logic [31:0] data, wr_word;
    logic err, addr_bad, mutex_bad, pulse_bad;
    run_txn(w, sz, uns, a, wd, lat, data, err, nrd, nwr, wr_word, addr_bad, mutex_bad, pulse_bad);
    check($sformatf("latency a=%08h", a), 32'(lat), 32'(elat));
    check($sformatf("resp_data a=%08h", a), data, ed);
    check($sformatf("resp_err a=%08h", a), {31'd0, err}, {31'd0, ee});
    check($sformatf("read_cycles a=%08h", a), 32'(nrd), 32'(enrd));
    check($sformatf("write_cycles a=%08h", a), 32'(nwr), 32'(enwr));
    check($sformatf("address a=%08h", a), {31'd0, addr_bad}, 32'd0);
    check($sformatf("rd_wr_overlap a=%08h", a), {31'd0, mutex_bad}, 32'd0);
    check($sformatf("resp_pulse a=%08h", a), {31'd0, pulse_bad}, 32'd0);
    if (enwr > 0) check($sformatf("write_data a=%08h", a), wr_word, ewd);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] med, mewd, ra, rwd;
    logic mee, rw, ru;
    logic [1:0] rsz;
    int mlat, mnrd, mnwr;
    logic [7:0] rdy_v, bsy_v, rv_v;
    logic wr_seen, rv_seen;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 3, 2, 0, 32'h0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h11,   32'h0,        32'hFFFFFFBE, 1'b0, 3, 2, 0, 32'h0};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        32'h000000BE, 1'b0, 3, 2, 0, 32'h0};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0, 3, 2, 0, 32'h0};
    tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'h0000DEAD, 1'b0, 3, 2, 0, 32'h0};
    tbl[6]  = '{1'b1, 2'd0, 1'b0, 32'h12,   32'h123456AA, 32'h0,        1'b0, 4, 2, 1, 32'hDEAABEEF};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEAABEEF, 1'b0, 3, 2, 0, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h12,   32'h01020304, 32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 32'h20,   32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};
    tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h2000, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0};

    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_flags", {26'd0, req_ready, busy, MemRead, MemWrite, resp_valid, resp_err}, 32'h20);
    check("reset_address", Address, 32'd0);
    check("reset_write_data", Write_data, 32'd0);
    check("reset_resp_data", resp_data, 32'd0);
    reset = 1'b0; mem_init = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      model(tbl[i].w, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, med, mee, mlat, mnrd, mnwr, mewd);
      exec(tbl[i].w, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd,
           tbl[i].ed, tbl[i].ee, tbl[i].lat, tbl[i].nrd, tbl[i].nwr, tbl[i].ewd);
    end

    // Reset during RMW_DATA of a byte store: write dropped, no response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_0055;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    wr_seen = MemWrite; rv_seen = resp_valid;
    reset = 1'b1;
    @(negedge clk);
    wr_seen |= MemWrite; rv_seen |= resp_valid;
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_ready_busy", {30'd0, req_ready, busy}, 32'h2);
    for (int c = 0; c < 5; c++) begin
      wr_seen |= MemWrite; rv_seen |= resp_valid;
      @(negedge clk);
    end
    check("aborted_write", {31'd0, wr_seen}, 32'd0);
    check("aborted_resp", {31'd0, rv_seen}, 32'd0);
    check("aborted_mem_word", mem[4], ref_mem[4]);
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, med, mee, mlat, mnrd, mnwr, mewd);
    exec(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, med, mee, mlat, mnrd, mnwr, mewd);

    // req_valid held high across loads: one accept per 4 cycles.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10;
    for (int i = 0; i < 8; i++) begin
      rdy_v[i] = req_ready; bsy_v[i] = busy; rv_v[i] = resp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("held_req_ready", {24'd0, rdy_v}, 32'h11);
    check("held_busy", {24'd0, bsy_v}, 32'hEE);
    check("held_resp_valid", {24'd0, rv_v}, 32'h88);

    // Random traffic against the model.
    for (int n = 0; n < 120; n++) begin
      rw  = 1'($urandom_range(0, 1));
      ru  = 1'($urandom_range(0, 1));
      rsz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1, 2, 3: ra = 32'($urandom_range(0, 8191));
        default: ra = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'd1) ra = ra & 32'hFFFF_FFFE;
        else if (rsz == 2'd2) ra = ra & 32'hFFFF_FFFC;
      end
      rwd = $urandom;
      model(rw, rsz, ru, ra, rwd, med, mee, mlat, mnrd, mnwr, mewd);
      exec(rw, rsz, ru, ra, rwd, med, mee, mlat, mnrd, mnwr, mewd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
